// File: rtl/sm_pkg.sv
// Shared types for the sequential multiplier: default width, the controller
// strobe bundle, and the running-sum strobe conflict test.
package sm_pkg;

    localparam int SM_WIDTH = 4;

    typedef struct packed {
        logic mdld;
        logic mrld;
        logic rsload;
        logic rsclear;
        logic rsshr;
    } sm_strobe_t;

    // Two or more running-sum strobes in the same cycle is an illegal combination.
    function automatic logic rs_conflict(input sm_strobe_t s);
        return (s.rsclear & s.rsload) | (s.rsclear & s.rsshr) | (s.rsload & s.rsshr);
    endfunction

endpackage

// File: rtl/sm_rs_reg.sv
// Running-sum register {C, HI, LO} with the multiplicand adder.
// Clear has priority over load, and load has priority over shift.
module sm_rs_reg
    import sm_pkg::*;
#(
    parameter int WIDTH = SM_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               shr,
    input  logic [WIDTH-1:0]   md,
    output logic [2*WIDTH:0]   rs
);

    logic [WIDTH:0] sum;

    // The adder output is (W+1) bits wide, so the carry of HI+MD lands in C.
    assign sum = {1'b0, rs[2*WIDTH-1:WIDTH]} + {1'b0, md};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs <= '0;
        end else if (clear) begin
            rs <= '0;
        end else if (load) begin
            rs[2*WIDTH:WIDTH] <= sum;
        end else if (shr) begin
            rs <= {1'b0, rs[2*WIDTH:1]};
        end
    end

endmodule

// File: rtl/sm_datapath.sv
// Datapath for the 4-bit add-then-shift multiplier. It holds MD, MR, the shift
// counter, the product capture register and the sticky protocol error flag.
module sm_datapath
    import sm_pkg::*;
#(
    parameter int WIDTH = SM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mdld,
    input  logic                 mrld,
    input  logic                 rsload,
    input  logic                 rsclear,
    input  logic                 rsshr,
    input  logic [WIDTH-1:0]     md_in,
    input  logic [WIDTH-1:0]     mr_in,
    output logic [WIDTH-1:0]     mr,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid,
    output logic                 protocol_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    sm_strobe_t        strobe;
    logic [WIDTH-1:0]  md_q;
    logic [WIDTH-1:0]  mr_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*WIDTH:0]  rs;
    logic              shift_eff;
    logic              over_shift;

    assign strobe = '{mdld: mdld, mrld: mrld, rsload: rsload,
                      rsclear: rsclear, rsshr: rsshr};

    // A shift only takes effect when neither clear nor load overrides it.
    assign shift_eff  = strobe.rsshr & ~strobe.rsclear & ~strobe.rsload;
    assign over_shift = shift_eff & (cnt == CNT_FULL);

    sm_rs_reg #(.WIDTH(WIDTH)) u_rs (
        .clk   (clk),
        .rst   (rst),
        .clear (strobe.rsclear),
        .load  (strobe.rsload),
        .shr   (strobe.rsshr),
        .md    (md_q),
        .rs    (rs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            md_q          <= '0;
            mr_q          <= '0;
            cnt           <= '0;
            product       <= '0;
            product_valid <= 1'b0;
            protocol_err  <= 1'b0;
        end else begin
            if (strobe.mdld) md_q <= md_in;
            if (strobe.mrld) mr_q <= mr_in;

            if (rs_conflict(strobe) || over_shift) protocol_err <= 1'b1;

            if (strobe.rsclear) begin
                cnt           <= '0;
                product_valid <= 1'b0;
            end else if (shift_eff) begin
                if (cnt == CNT_LAST) begin
                    // (RS >> 1) truncated to 2W bits is {C, HI, LO[W-1:1]}.
                    product       <= rs[2*WIDTH:1];
                    product_valid <= 1'b1;
                    cnt           <= CNT_FULL;
                end else if (cnt != CNT_FULL) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign mr = mr_q;

endmodule
